dice_game_ctrl: RTL and testbench
=================================

# dice_game_ctrl

Two-player game controller that shares one electronic dice (the `roll` block: clk, rst, button, throw[2:0]) between two requesters. It arbitrates player requests round-robin and drives the dice button for a pseudo-random number of cycles. It captures the settled throw, accumulates per-player scores and declares the first player to reach a target score. It sits directly above `roll`: `button` feeds `roll.button` and `roll.throw` feeds `throw`.

## Interface
- `TARGET`, default 20: winning score threshold; legal range 1..58.
- `MIN_ROLL`, default 4: minimum button-high cycles per throw; legal range 1..8.
- `SEED`, default 8'hA5: LFSR reset value; must be nonzero.

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  2  level roll requests; bit0 = player 0, bit1 = player 1.
- `throw`  in  3  dice value from `roll`.
- `button`  out  1  dice button drive.
- `grant`  out  2  one-hot player currently being served; 00 when none.
- `done`  out  1  one-cycle pulse; `result` and scores are updated.
- `result`  out  3  last captured throw, raw value.
- `score0`, `score1`  out  6 each  accumulated scores.
- `winner`  out  2  one-hot winning player; sticky.
- `game_over`  out  1  high once a winner exists; sticky.
- `err`  out  1  sticky flag: a throw outside 1..6 was captured.

## Operation
- **Reset values.** All outputs are registered. On reset: `button`=0, `grant`=00, `done`=0, `result`=000, scores=0, `winner`=00, `game_over`=0, `err`=0, state=IDLE, `lfsr`=SEED. The last-served pointer resets to player 1, so player 0 wins the first tie.
- **LFSR.** 8-bit Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1. It shifts left every non-reset cycle; the feedback is lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] into bit0.
- **State machine.** States are IDLE, ROLL, SETTLE, CAPTURE, OVER.
  - **IDLE.** If `req` is nonzero, pick a player:
    - Only one request bit set: that player.
    - Both set: the player not last served.
    - Load `cnt` = MIN_ROLL + lfsr[2:0], 4 bits, range MIN_ROLL..MIN_ROLL+7.
    - Set `grant` and go to ROLL.
  - **ROLL.** `button`=1. Decrement `cnt`; when `cnt`==1, go to SETTLE. `button` is high for exactly N = loaded `cnt` cycles.
  - **SETTLE.** One cycle with `button`=0 so that `throw` is stable.
  - **CAPTURE.** One cycle.
    - `done`=1 and `result`=`throw`.
    - The granted player's score += `throw` when `throw` is in 1..6. Otherwise add 0 and set `err`.
    - Update the last-served pointer.
    - If the new score is >= TARGET: set `winner` to the granted player, set `game_over`, go to OVER. Otherwise go to IDLE.
    - `grant` clears on leaving CAPTURE.
  - **OVER.** `button`=0 and `grant`=00. Requests are ignored, scores, `result` and `winner` are held, and `done` stays 0. Only `rst` exits OVER.
- **Score width.** Maximum score is TARGET+5 <= 63, so 6 bits never overflows.
- **Request changes.** `req` is sampled only in IDLE. Deasserting `req` mid-throw does not abort the throw.
- **Reset mid-throw.** `rst` in any state forces reset values at that edge. `button` drops on the same edge and the partial throw is discarded, with no `done` and no score change.

## Timing
- `req` is high in IDLE at cycle t. Then:
  - `grant` and `button` are high from cycle t+1 through t+N (ROLL).
  - t+N+1 is SETTLE: `grant` still high, `button`=0.
  - t+N+2 is CAPTURE: `done`=1; `result` and scores show the new values in the same cycle; `grant` is still high.
  - t+N+3 is IDLE, or OVER if the game was won.
- Request-to-`done` latency is N+2 cycles after the sampling cycle. Back-to-back throws are separated by at least one IDLE cycle.
- The one-hot `grant` is stable for the whole ROLL..CAPTURE window. The next arbitration decision happens in the IDLE cycle after CAPTURE.
- The new `score` is visible in the same cycle `done` is high. `winner` and `game_over` assert in the cycle after the winning CAPTURE, on entry to OVER.

## Test plan
- **Reset.** Hold `rst` for 3 cycles with `req`=11 -> all outputs at reset values; `button` is never high.
- **Single throw.** After reset with SEED=A5, pulse `req`=01 for one cycle -> `grant`=01. `button` is high for exactly MIN_ROLL+lfsr[2:0] cycles, with the LFSR modelled in the bench. `done` pulses N+2 cycles after the sample and `score0`==`result`; `score1`=0.
- **Arbitration.** Hold `req`=11 continuously -> grants alternate 01,10,01,10,... with the first grant = 01. Each `done` adds to the correct score.
- **Win.** Force `throw`=6 from a bench stub, TARGET=20, `req`=01 held -> `score0` reads 6,12,18,24. `winner`=01 and `game_over`=1 after the 4th `done`. Further requests give no `button` and no `done`.
- **Invalid throw.** Stub `throw`=7 -> `result`=7, score unchanged, `err`=1 sticky; the next valid throw still scores normally.
- **Reset mid-roll.** Assert `rst` on the 2nd ROLL cycle -> `button`=0 and `grant`=00 at the next edge, no `done`, scores 0. A new request after release runs a full throw.

Source files
------------

// File: rtl/dice_game_ctrl.sv
`timescale 1ns/1ps
// Two-player dice game controller: round-robin arbitration of one shared dice,
// pseudo-random button hold time, score accumulation and winner detection.
module dice_game_ctrl #(
  parameter int unsigned TARGET   = 20,
  parameter int unsigned MIN_ROLL = 4,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] throw,
  output logic       button,
  output logic [1:0] grant,
  output logic       done,
  output logic [2:0] result,
  output logic [5:0] score0,
  output logic [5:0] score1,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, ROLL, SETTLE, CAPTURE, OVER} state_t;

  localparam logic [5:0] TARGET_W   = 6'(TARGET);
  localparam logic [3:0] MIN_ROLL_W = 4'(MIN_ROLL);

  state_t     state, state_nxt;
  logic [7:0] lfsr, lfsr_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       last_p1, last_p1_nxt;
  logic       button_nxt, done_nxt, game_over_nxt, err_nxt;
  logic [1:0] grant_nxt, winner_nxt;
  logic [2:0] result_nxt;
  logic [5:0] score0_nxt, score1_nxt;

  logic       pick_p1;
  logic       throw_ok;
  logic [5:0] granted_score;

  // On a tie the player not served last wins; last_p1 is 1 when player 1 was.
  assign pick_p1       = req[1] & (~req[0] | ~last_p1);
  assign throw_ok      = (throw != 3'd0) && (throw != 3'd7);
  assign granted_score = grant[1] ? score1 : score0;

  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    cnt_nxt       = cnt;
    last_p1_nxt   = last_p1;
    button_nxt    = 1'b0;
    grant_nxt     = grant;
    done_nxt      = 1'b0;
    result_nxt    = result;
    score0_nxt    = score0;
    score1_nxt    = score1;
    winner_nxt    = winner;
    game_over_nxt = game_over;
    err_nxt       = err;

    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt  = pick_p1 ? 2'b10 : 2'b01;
          cnt_nxt    = MIN_ROLL_W + {1'b0, lfsr[2:0]};
          button_nxt = 1'b1;
          state_nxt  = ROLL;
        end
      end
      ROLL: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = SETTLE;
        end else begin
          button_nxt = 1'b1;
        end
      end
      SETTLE: begin
        // Results are registered so they appear together with done in CAPTURE.
        done_nxt    = 1'b1;
        result_nxt  = throw;
        last_p1_nxt = grant[1];
        state_nxt   = CAPTURE;
        if (!throw_ok) begin
          err_nxt = 1'b1;
        end else if (grant[1]) begin
          score1_nxt = score1 + {3'b000, throw};
        end else begin
          score0_nxt = score0 + {3'b000, throw};
        end
      end
      CAPTURE: begin
        grant_nxt = 2'b00;
        if (granted_score >= TARGET_W) begin
          winner_nxt    = grant;
          game_over_nxt = 1'b1;
          state_nxt     = OVER;
        end else begin
          state_nxt = IDLE;
        end
      end
      OVER: begin
        grant_nxt = 2'b00;
      end
      default: begin
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      cnt       <= 4'd0;
      last_p1   <= 1'b1;
      button    <= 1'b0;
      grant     <= 2'b00;
      done      <= 1'b0;
      result    <= 3'd0;
      score0    <= 6'd0;
      score1    <= 6'd0;
      winner    <= 2'b00;
      game_over <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      cnt       <= cnt_nxt;
      last_p1   <= last_p1_nxt;
      button    <= button_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      result    <= result_nxt;
      score0    <= score0_nxt;
      score1    <= score1_nxt;
      winner    <= winner_nxt;
      game_over <= game_over_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_dice_game_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for dice_game_ctrl: a transaction-level game model predicts
// each throw; a negedge monitor checks every done pulse and the win.
module tb_dice_game_ctrl;

  localparam int TARGET   = 20;
  localparam int MIN_ROLL = 4;
  localparam int SEED     = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b11;
  logic [2:0] throw = 3'd0;
  logic       button, done, game_over, err;
  logic [1:0] grant, winner;
  logic [2:0] result;
  logic [5:0] score0, score1;

  dice_game_ctrl #(.TARGET(TARGET), .MIN_ROLL(MIN_ROLL), .SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .req(req), .throw(throw),
    .button(button), .grant(grant), .done(done), .result(result),
    .score0(score0), .score1(score1), .winner(winner),
    .game_over(game_over), .err(err)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Dice stub: wiggles while the button is held, then settles to a value chosen at press.
  int   force_throw = -1;
  int   settle_val  = 0;
  logic drv_prev_btn = 1'b0;
  always @(posedge clk) begin
    #1;
    if (button && !drv_prev_btn)
      settle_val = (force_throw < 0) ? int'($urandom_range(0, 7)) : force_throw;
    drv_prev_btn = button;
    if (button) throw = (force_throw < 0) ? 3'($urandom_range(0, 7)) : 3'(force_throw);
    else        throw = 3'(settle_val);
  end

  typedef struct {
    int grant; int result; int s0; int s1; int err; int n;
  } exp_t;

  exp_t sb_q[$];
  int   win_q[$];
  exp_t m_e, mon_e;

  int m_lfsr = SEED, m_busy = 0, m_player = 0, m_last = 1, m_n = 0, m_err = 0;
  int m_score[2] = '{0, 0};
  bit m_over = 1'b0;

  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  // Game model: m_busy counts edges left in the current throw (N ROLL, SETTLE, CAPTURE).
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr = SEED; m_busy = 0; m_last = 1; m_over = 1'b0; m_err = 0;
      m_score[0] = 0; m_score[1] = 0;
    end else begin
      if (!m_over) begin
        if (m_busy == 0) begin
          if (req != 2'b00) begin
            if (req == 2'b01)      m_player = 0;
            else if (req == 2'b10) m_player = 1;
            else                   m_player = 1 - m_last;
            m_n    = MIN_ROLL + (m_lfsr % 8);
            m_busy = m_n + 2;
          end
        end else begin
          if (m_busy == 2) begin
            if (throw >= 3'd1 && throw <= 3'd6) m_score[m_player] += int'(throw);
            else m_err = 1;
            m_last     = m_player;
            m_e.grant  = 1 << m_player;
            m_e.result = int'(throw);
            m_e.s0     = m_score[0];
            m_e.s1     = m_score[1];
            m_e.err    = m_err;
            m_e.n      = m_n;
            sb_q.push_back(m_e);
          end else if (m_busy == 1) begin
            if (m_score[m_player] >= TARGET) begin
              m_over = 1'b1;
              win_q.push_back(1 << m_player);
            end
          end
          m_busy--;
        end
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  int   done_count = 0;
  int   btn_cycles = 0;
  int   lat = 0;
  logic mon_prev_btn = 1'b0;
  logic mon_prev_go  = 1'b0;
  int   grant_log[$];
  int   score0_log[$];

  always @(negedge clk) begin
    if (rst) begin
      btn_cycles = 0; lat = 0; mon_prev_btn = 1'b0; mon_prev_go = 1'b0;
    end else begin
      if (button) btn_cycles++;
      if (button && !mon_prev_btn) lat = 1;
      else if (lat > 0) lat++;
      mon_prev_btn = button;
      if (done) begin
        done_count++;
        grant_log.push_back(int'(grant));
        score0_log.push_back(int'(score0));
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("grant",         grant,     mon_e.grant);
          checkOutput("result",        result,    mon_e.result);
          checkOutput("score0",        score0,    mon_e.s0);
          checkOutput("score1",        score1,    mon_e.s1);
          checkOutput("err",           err,       mon_e.err);
          checkOutput("button_cycles", btn_cycles, mon_e.n);
          checkOutput("done_latency",  lat,       mon_e.n + 2);
          checkOutput("over_at_done",  game_over, 0);
        end
        btn_cycles = 0;
        lat = 0;
      end
      if (game_over && !mon_prev_go) begin
        if (win_q.size() == 0) checkOutput("unexpected_game_over", 1, 0);
        else checkOutput("winner", winner, win_q.pop_front());
      end
      if (game_over) checkOutput("quiet_in_over", {button, done, grant}, 0);
      mon_prev_go = game_over;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input int cycles);
    req = r;
    tick(cycles);
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    tick(cycles);
    rst = 1'b0;
  endtask

  task automatic waitDones(input int k, input int budget);
    int target;
    int waited;
    target = done_count + k;
    waited = 0;
    while (done_count < target && waited < budget) begin
      tick(1);
      waited++;
    end
    checkOutput("done_wait", int'(done_count >= target), 1);
  endtask

  initial begin
    int saved_done;
    int waited;

    tick(1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_outputs",
                  {button, grant, done, result, score0, score1, winner, game_over, err}, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // First throw from reset: lfsr=A5 gives N = MIN_ROLL + 5.
    applyStimulus(2'b01, 1);
    req = 2'b00;
    waitDones(1, 40);
    checkOutput("single_score1", score1, 0);
    checkOutput("single_grant", grant_log.size() > 0 ? grant_log[grant_log.size() - 1] : 0, 1);

    doReset(2);
    grant_log.delete();
    req = 2'b11;
    waitDones(4, 200);
    req = 2'b00;
    checkOutput("arb_grant0", grant_log.size() > 0 ? grant_log[0] : 0, 1);
    checkOutput("arb_grant1", grant_log.size() > 1 ? grant_log[1] : 0, 2);
    checkOutput("arb_grant2", grant_log.size() > 2 ? grant_log[2] : 0, 1);
    checkOutput("arb_grant3", grant_log.size() > 3 ? grant_log[3] : 0, 2);
    tick(30);

    doReset(2);
    applyStimulus(2'b10, 1);
    req = 2'b00;
    waited = 0;
    while (waited < 20) begin
      @(negedge clk);
      if (button) break;
      waited++;
    end
    checkOutput("midroll_button_seen", button, 1);
    @(posedge clk);
    #1;
    checkOutput("midroll_grant_before", grant, 2);
    saved_done = done_count;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midroll_button", button, 0);
    checkOutput("midroll_grant",  grant,  0);
    checkOutput("midroll_scores", {score0, score1}, 0);
    rst = 1'b0;
    tick(15);
    checkOutput("midroll_no_done", done_count, saved_done);
    applyStimulus(2'b01, 1);
    req = 2'b00;
    waitDones(1, 40);
    checkOutput("after_midroll_grant", grant_log[grant_log.size() - 1], 1);
    tick(3);

    doReset(2);
    force_throw = -1;
    repeat (40) applyStimulus(2'($urandom_range(0, 3)), $urandom_range(1, 12));
    req = 2'b00;
    tick(30);

    doReset(2);
    force_throw = 6;
    score0_log.delete();
    req = 2'b01;
    waited = 0;
    while (!game_over && waited < 200) begin
      tick(1);
      waited++;
    end
    checkOutput("win_reached", game_over, 1);
    checkOutput("win_score_a", score0_log.size() > 0 ? score0_log[0] : 0, 6);
    checkOutput("win_score_b", score0_log.size() > 1 ? score0_log[1] : 0, 12);
    checkOutput("win_score_c", score0_log.size() > 2 ? score0_log[2] : 0, 18);
    checkOutput("win_score_d", score0_log.size() > 3 ? score0_log[3] : 0, 24);
    checkOutput("win_winner", winner, 1);
    saved_done = done_count;
    req = 2'b11;
    tick(40);
    checkOutput("over_no_done", done_count, saved_done);
    checkOutput("over_score0_held", score0, 24);
    checkOutput("over_sticky", {winner, game_over}, 3'b011);

    doReset(2);
    force_throw = 7;
    applyStimulus(2'b01, 1);
    req = 2'b00;
    waitDones(1, 40);
    checkOutput("invalid_result", result, 7);
    checkOutput("invalid_score0", score0, 0);
    checkOutput("invalid_err",    err,    1);
    force_throw = 3;
    tick(2);
    applyStimulus(2'b01, 1);
    req = 2'b00;
    waitDones(1, 40);
    checkOutput("valid_after_err_score0", score0, 3);
    checkOutput("err_sticky", err, 1);
    tick(5);

    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
